uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART_TX transmitter between NUM_REQ byte sources using round-robin arbitration with packet locking. A requester keeps the grant until it sends a byte marked `last`, so its message is never interleaved with another source. The block sits between the on-chip byte producers (status reporter, debug dump, CPU port) and UART_TX. It drives UART_TX's `start`/`data_in` and watches `busy`.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- BUSY_TIMEOUT, 8: cycles to wait for `tx_busy` to rise after a start pulse.
- HOLD_TIMEOUT, 4096: idle cycles a locked requester may hold the grant between bytes of a packet.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid; must stay high until the matching `req_ready`.
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]; must stay stable while valid.
- req_last  in  NUM_REQ  byte is the final byte of the packet; stable while valid.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- tx_start  out  1  start pulse to UART_TX.
- tx_data  out  8  byte to UART_TX.
- tx_busy  in  1  UART_TX `busy`.
- grant_id  out  $clog2(NUM_REQ)  current owner index.
- grant_active  out  1  an owner currently holds the transmitter (packet in progress).
- err_timeout  out  1  sticky flag: busy never rose, or a hold timeout expired; cleared only by reset.

## Operation
- Reset (asynchronous): state=IDLE. All outputs are 0. The round-robin pointer rr_ptr is 0. Counters are 0.
- States: IDLE, ACCEPT, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE:
  - Scan `req_valid` starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - On a winner: grant_q = winner, data_q = its `req_data`, last_q = its `req_last`; go to ACCEPT.
  - With no valid request, stay in IDLE.
- ACCEPT (exactly 1 cycle): `req_ready[grant_q]` = 1, `tx_start` = 1, `tx_data` = data_q. Go to WAIT_BUSY.
- WAIT_BUSY:
  - If `tx_busy` = 1, go to WAIT_DONE.
  - Otherwise increment the wait counter. If it reaches BUSY_TIMEOUT, set `err_timeout` and treat the byte as finished (same exit as WAIT_DONE).
- WAIT_DONE: wait for `tx_busy` = 0. Then:
  - If last_q: rr_ptr = (grant_q+1) mod NUM_REQ and go to IDLE.
  - Otherwise go to HOLD and clear the hold counter.
- HOLD: only requester grant_q is considered.
  - If `req_valid[grant_q]`: capture data and last, go to ACCEPT.
  - Otherwise increment the hold counter. On reaching HOLD_TIMEOUT, set `err_timeout`, rr_ptr = grant_q+1, and go to IDLE. This releases the lock.
- `tx_data` holds data_q in every state; it changes only when a new byte is captured.
- `grant_id` = grant_q in all states. `grant_active` = 1 in every state except IDLE.
- Requests from other sources while locked are neither accepted nor dropped; they wait.
- A requester dropping `req_valid` before `req_ready` violates the protocol. Behaviour is undefined, but the controller must not hang; the hold timeout recovers it.

## Timing
- Request seen in IDLE at cycle N: `tx_start` and `req_ready` are high at N+1.
- UART_TX samples `start` at the N+1 edge. `tx_busy` is high from N+2, where WAIT_BUSY observes it.
- Gap between the end of one frame and the next start:
  - 2 cycles within a locked packet (WAIT_DONE→HOLD→ACCEPT).
  - 2 cycles when re-arbitrating (WAIT_DONE→IDLE→ACCEPT).
- `tx_start` is never high while `tx_busy` is high.
- At most one `req_ready` bit is high, and only in ACCEPT.
- Reset mid-frame: the controller returns to IDLE at once. UART_TX shares the reset, so no half frame is resumed.

## Structure
- Shared package uart_pkg: the state encoding (3-bit localparams IDLE..HOLD) and the UART default CLOCK_DIV constant, so both UART blocks and their benches agree.
- One sub-module: rr_pick. It is combinational: given a valid vector and a start pointer, it returns the winner index and a found flag. It is reused by future bus arbiters.
- Counters: the wait counter is $clog2(BUSY_TIMEOUT+1) bits and the hold counter is $clog2(HOLD_TIMEOUT+1) bits; both saturate at their limit.

## Test plan
- Single byte: requester 2 sends 0x55 with last=1 → one `tx_start`, `tx_data`=0x55, `req_ready`=0100 one cycle later; the UART line shows 0x55; returns to IDLE; rr_ptr=3.
- Round-robin: all four sources send one last=1 byte each, starting at rr_ptr=0 → grant order 0,1,2,3; repeated with rr_ptr=2 → order 2,3,0,1.
- Packet lock: source 1 sends "HI\n" (last on '\n') while source 0 holds valid throughout → bytes 0x48, 0x49, 0x0A from source 1, then source 0's byte.
- Hold timeout: source 3 sends a last=0 byte, then drops valid; HOLD_TIMEOUT=16 → after 16 idle cycles `err_timeout`=1, lock released, waiting source 0 is then granted.
- Busy timeout: tie `tx_busy`=0 → after `tx_start`, 8 cycles later `err_timeout`=1 and the FSM proceeds to the next request.
- Reset during WAIT_DONE → all outputs 0 at the next sample; a pending request is re-granted cleanly after reset deasserts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the default baud divider,
// so the UART blocks and their benches agree on both.
package uart_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ACCEPT    = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_HOLD      = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      ACCEPT    = ST_ACCEPT,
      WAIT_BUSY = ST_WAIT_BUSY,
      WAIT_DONE = ST_WAIT_DONE,
      HOLD      = ST_HOLD
   } arb_state_t;

   localparam int CLOCK_DIV = 434;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid at or after
// i_start, wrapping modulo N.
module rr_pick
   import uart_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_start,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   int w_pos;

   // Scan from the far end so the candidate closest to i_start is written last.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_pos   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_pos = int'(i_start) + k;
         if (w_pos >= N) w_pos = w_pos - N;
         if (i_valid[IW'(w_pos)]) begin
            o_idx   = IW'(w_pos);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX between NUM_REQ byte sources: round-robin between packets,
// locked to one source until it sends a byte marked last.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 8,
   parameter int HOLD_TIMEOUT = 4096
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       grant_active,
   output logic                       err_timeout
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(BUSY_TIMEOUT + 1);
   localparam int HW = $clog2(HOLD_TIMEOUT + 1);

   arb_state_t         r_state;
   logic [IW-1:0]      r_grant;
   logic [IW-1:0]      r_rr_ptr;
   logic [7:0]         r_data;
   logic               r_last;
   logic               r_start;
   logic               r_active;
   logic               r_err;
   logic [NUM_REQ-1:0] r_ready;
   logic [WW-1:0]      r_wait_cnt;
   logic [HW-1:0]      r_hold_cnt;

   logic [IW-1:0]      w_pick_idx;
   logic               w_pick_found;
   logic               w_busy_to;
   logic               w_byte_done;

   function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
   endfunction

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .i_valid (req_valid),
      .i_start (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   // A missing busy edge ends the byte exactly like a normal busy fall.
   assign w_busy_to   = (r_state == WAIT_BUSY) && !tx_busy &&
                        (r_wait_cnt == WW'(BUSY_TIMEOUT - 1));
   assign w_byte_done = w_busy_to || ((r_state == WAIT_DONE) && !tx_busy);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_data     <= '0;
         r_last     <= 1'b0;
         r_start    <= 1'b0;
         r_active   <= 1'b0;
         r_err      <= 1'b0;
         r_ready    <= '0;
         r_wait_cnt <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_ready <= '0;
         r_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_found) begin
                  r_grant              <= w_pick_idx;
                  r_data               <= req_data[8*w_pick_idx +: 8];
                  r_last               <= req_last[w_pick_idx];
                  r_ready[w_pick_idx]  <= 1'b1;
                  r_start              <= 1'b1;
                  r_active             <= 1'b1;
                  r_state              <= ACCEPT;
               end
            end
            ACCEPT: begin
               r_wait_cnt <= '0;
               r_state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy)
                  r_state <= WAIT_DONE;
               else if (r_wait_cnt != WW'(BUSY_TIMEOUT))
                  r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            WAIT_DONE: begin
            end
            HOLD: begin
               if (req_valid[r_grant]) begin
                  r_data           <= req_data[8*r_grant +: 8];
                  r_last           <= req_last[r_grant];
                  r_ready[r_grant] <= 1'b1;
                  r_start          <= 1'b1;
                  r_state          <= ACCEPT;
               end else if (r_hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                  r_hold_cnt <= HW'(HOLD_TIMEOUT);
                  r_err      <= 1'b1;
                  r_rr_ptr   <= f_next(r_grant);
                  r_active   <= 1'b0;
                  r_state    <= IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_byte_done) begin
            if (w_busy_to) r_err <= 1'b1;
            if (r_last) begin
               r_rr_ptr <= f_next(r_grant);
               r_active <= 1'b0;
               r_state  <= IDLE;
            end else begin
               r_hold_cnt <= '0;
               r_state    <= HOLD;
            end
         end
      end
   end

   assign req_ready    = r_ready;
   assign tx_start     = r_start;
   assign tx_data      = r_data;
   assign grant_id     = r_grant;
   assign grant_active = r_active;
   assign err_timeout  = r_err;

endmodule
